pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges the following events into one consistent set of per-stage write-enables, bubble injects and flushes:
- load-use hazards (ID vs EX),
- taken branches resolved in EX,
- multi-cycle MUL/DIV operations in EX,
- data-memory wait states in MEM.

A small FSM tracks the multi-cycle conditions. Outputs are Mealy, so stalls take effect in the cycle the event is seen.

## Interface
Parameters:
- PERF_W, 32, width of each performance counter (used only with PERF_COUNTERS_EN).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of instruction in EX
- if_id_rs1, if_id_rs2  in  5 each  source registers of instruction in ID
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mdu_start  in  1  EX holds a MUL/DIV op (level, held while op sits in EX)
- mdu_done  in  1  MDU result valid this cycle
- dmem_req  in  1  MEM stage is accessing data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- ex_mem_write  out  1  EX/MEM register enable
- control_mux  out  1  1 = load NOP control into ID/EX
- ex_bubble  out  1  1 = load NOP into EX/MEM
- mem_bubble  out  1  1 = load NOP into MEM/WB
- if_id_flush, id_ex_flush  out  1 each  clear the register to NOP
- perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt  out  PERF_W each  event counters

## Operation
FSM states: RUN, MDU_WAIT, MEM_WAIT. A pending-MDU flag records MDU_WAIT interrupted by MEM_WAIT.

Condition definitions:
- **mem_stall** = dmem_req & ~dmem_ready. Highest priority, from any state.
  - All write-enables (pc, if_id, id_ex, ex_mem) = 0; mem_bubble = 1.
  - Next state MEM_WAIT. pending-MDU is set if the current state is MDU_WAIT, or if in RUN with mdu_start & ~mdu_done.
- **mdu_stall**: state MDU_WAIT & ~mdu_done, or RUN & mdu_start & ~mdu_done.
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0; ex_bubble = 1.
  - Next state MDU_WAIT.
  - In the mdu_done cycle the pipeline advances normally and the state returns to RUN.
- **MEM_WAIT exit**: on dmem_ready, the state returns to MDU_WAIT if pending-MDU is set (flag cleared), else RUN. That cycle follows RUN/MDU_WAIT rules.
- **Load-use** (only when neither stall is active): id_ex_mem_read & id_ex_rd != 0 & (id_ex_rd == if_id_rs1 | id_ex_rd == if_id_rs2).
  - pc_write = 0, if_id_write = 0, control_mux = 1; all other enables 1.
  - Lasts exactly one cycle (combinational; no state).
- **Branch**: branch_taken is honoured only when EX advances (no mem_stall, no mdu_stall).
  - if_id_flush = 1, id_ex_flush = 1, pc_write = 1.
  - Overrides a simultaneous load-use: control_mux = 0, if_id_write = 1.
- **Idle**: all enables = 1, all bubbles/flushes = 0.
- **Flush and stall flags**: a flush never coexists with any *_write = 0 on the same register.

## Timing
- Reset (async assert, sync-released by the top level): state RUN, pending-MDU = 0, counters = 0.
- Outputs during reset equal the idle values, given the inputs. With all inputs 0: every write = 1, every bubble/flush = 0.
- Combinational input-to-output path; zero-cycle latency. State updates on clk rising edge.
- An MDU op of N cycles (mdu_done in the N-th cycle after entering EX) stalls IF–EX for N-1 cycles.
- A dmem_ready that arrives in the same cycle as dmem_req causes no stall.
- rst_n asserted mid-MDU_WAIT or MEM_WAIT returns the FSM to RUN immediately and discards pending-MDU.

## Configuration
- PERF_COUNTERS_EN defined:
  - perf_stall_cnt increments every cycle any *_write is 0.
  - perf_flush_cnt increments on each honoured branch.
  - perf_bubble_cnt increments on control_mux, ex_bubble or mem_bubble.
  - All counters wrap at 2^PERF_W.
- Not defined: counter ports exist and are tied to 0; no counter flops.

## Structure
- Shared package/include pipeline_ctrl_pkg: FSM state encodings (RUN = 2'd0, MDU_WAIT = 2'd1, MEM_WAIT = 2'd2) and REG_X0 = 5'd0.
- One sub-module, stall_perf_counters, instantiated only under PERF_COUNTERS_EN.
- Load-use compare stays inline.

## Test plan
- id_ex_mem_read = 1, id_ex_rd = 5, if_id_rs2 = 5 → one cycle with pc_write = 0, if_id_write = 0, control_mux = 1. Same with id_ex_rd = 0 → no stall.
- mdu_start held, mdu_done asserted in the 4th cycle → 3 cycles of pc/if_id/id_ex/ex_mem writes = 0 with ex_bubble = 1; 4th cycle all enables = 1; state back to RUN.
- dmem_req = 1, dmem_ready low for 2 cycles → 2 cycles of all writes 0 with mem_bubble = 1, released on ready.
- Mem stall arrives during MDU_WAIT, ready after 2 cycles, mdu_done 3 cycles later → MEM_WAIT then MDU_WAIT resumes; no lost MDU stall.
- branch_taken together with a load-use match → if_id_flush = id_ex_flush = 1, pc_write = 1, control_mux = 0. branch_taken during mem_stall → no flush until the stall releases.
- rst_n pulsed low mid-MDU_WAIT → state RUN, outputs idle. With PERF_COUNTERS_EN, counters read 0 after reset and 3 after the MDU scenario above.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding
// and the architectural zero register index.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/stall_perf_counters.sv
// Wrapping event counters for stall cycles, honoured branch flushes and bubble
// injects. Only compiled when PERF_COUNTERS_EN is defined.
`ifdef PERF_COUNTERS_EN
module stall_perf_counters #(
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              bubble_i,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o,
  output logic [PERF_W-1:0] bubble_cnt_o
);

  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_i  ? stall_cnt_q  + PERF_W'(1) : stall_cnt_q;
    flush_cnt_d  = flush_i  ? flush_cnt_q  + PERF_W'(1) : flush_cnt_q;
    bubble_cnt_d = bubble_i ? bubble_cnt_q + PERF_W'(1) : bubble_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
`endif

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (Mealy outputs).
// Optional event counters are built when PERF_COUNTERS_EN is defined.
module pipeline_stall_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_rd,
  input  logic [4:0]        if_id_rs1,
  input  logic [4:0]        if_id_rs2,
  input  logic              branch_taken,
  input  logic              mdu_start,
  input  logic              mdu_done,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              control_mux,
  output logic              ex_bubble,
  output logic              mem_bubble,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_bubble_cnt
);
  import pipeline_ctrl_pkg::*;

  ctrl_state_e state_q, state_d, eff_state;
  logic        pending_q, pending_d;
  logic        mem_stall, mdu_stall, load_use, branch_ok;

  // Leaving MEM_WAIT, the cycle behaves as the state being resumed.
  always_comb begin
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = pending_q ? MDU_WAIT : RUN;
    end
    mem_stall = dmem_req & ~dmem_ready;
    mdu_stall = ~mem_stall & ~mdu_done &
                ((eff_state == MDU_WAIT) | ((eff_state == RUN) & mdu_start));
    load_use  = id_ex_mem_read & (id_ex_rd != REG_X0) &
                ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
    branch_ok = branch_taken & ~mem_stall & ~mdu_stall;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (mem_stall) begin
      state_d = MEM_WAIT;
      if ((state_q == MDU_WAIT) || ((state_q == RUN) && mdu_start && !mdu_done)) begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = 1'b0;
      state_d   = mdu_stall ? MDU_WAIT : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    control_mux  = 1'b0;
    ex_bubble    = 1'b0;
    mem_bubble   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (mem_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_bubble   = 1'b1;
    end else if (mdu_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      ex_bubble    = 1'b1;
    end else if (branch_ok) begin
      // Flushed instructions make any load-use hazard in ID moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      control_mux = 1'b1;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic any_stall, any_bubble;

  assign any_stall  = ~(pc_write & if_id_write & id_ex_write & ex_mem_write);
  assign any_bubble = control_mux | ex_bubble | mem_bubble;

  stall_perf_counters #(
    .PERF_W(PERF_W)
  ) u_perf (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .stall_i     (any_stall),
    .flush_i     (branch_ok),
    .bubble_i    (any_bubble),
    .stall_cnt_o (perf_stall_cnt),
    .flush_cnt_o (perf_flush_cnt),
    .bubble_cnt_o(perf_bubble_cnt)
  );
`else
  assign perf_stall_cnt  = '0;
  assign perf_flush_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus a
// randomized run against an outstanding-operation reference model.
module tb_pipeline_stall_ctrl;

  localparam int PERF_W = 32;
  // {pc, if_id, id_ex, ex_mem, control_mux, ex_bubble, mem_bubble, if_id_flush, id_ex_flush}
  localparam logic [8:0] IDLE_K = 9'b1111_000_00;
  localparam logic [8:0] LU_K   = 9'b0011_100_00;
  localparam logic [8:0] MDU_K  = 9'b0000_010_00;
  localparam logic [8:0] MEM_K  = 9'b0000_001_00;
  localparam logic [8:0] BR_K   = 9'b1111_000_11;

  logic clk = 1'b0;
  logic rst_n;
  logic id_ex_mem_read, branch_taken, mdu_start, mdu_done, dmem_req, dmem_ready;
  logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic control_mux, ex_bubble, mem_bubble, if_id_flush, id_ex_flush;
  logic [PERF_W-1:0] perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt;
  logic [8:0] outv;

  int checks = 0;
  int errors = 0;

  bit          m_inflight;
  logic [31:0] m_stall_n, m_flush_n, m_bubble_n;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.PERF_W(PERF_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .branch_taken   (branch_taken),
    .mdu_start      (mdu_start),
    .mdu_done       (mdu_done),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_write    (id_ex_write),
    .ex_mem_write   (ex_mem_write),
    .control_mux    (control_mux),
    .ex_bubble      (ex_bubble),
    .mem_bubble     (mem_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
  );

  assign outv = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 control_mux, ex_bubble, mem_bubble, if_id_flush, id_ex_flush};

  // Priority: memory wait, outstanding MDU op, taken branch, load-use, idle.
  function automatic logic [8:0] model_out();
    bit ms, ds, lu;
    ms = dmem_req && !dmem_ready;
    ds = !ms && !mdu_done && (m_inflight || mdu_start);
    lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
         ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    if (ms)                return MEM_K;
    else if (ds)           return MDU_K;
    else if (branch_taken) return BR_K;
    else if (lu)           return LU_K;
    return IDLE_K;
  endfunction

  task automatic drive(input logic req, input logic rdy, input logic st, input logic dn,
                       input logic br, input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2);
    dmem_req = req; dmem_ready = rdy; mdu_start = st; mdu_done = dn;
    branch_taken = br; id_ex_mem_read = mr; id_ex_rd = rd; if_id_rs1 = r1; if_id_rs2 = r2;
  endtask

  // Called at a falling edge with inputs applied; checks, then advances one cycle.
  task automatic cyc(input string tag, input logic [8:0] k, input bit use_k);
    logic [8:0]  e;
    logic [31:0] es, ef, eb;
    #1;
    if (!rst_n) begin
      m_inflight = 0; m_stall_n = 0; m_flush_n = 0; m_bubble_n = 0;
    end
    e = model_out();
    checks++;
    assert (outv === e) else begin
      errors++;
      $error("FAIL %s: outputs %b, model expects %b", tag, outv, e);
    end
    if (use_k) begin
      checks++;
      assert (outv === k) else begin
        errors++;
        $error("FAIL %s_k: outputs %b, expected %b", tag, outv, k);
      end
    end
`ifdef PERF_COUNTERS_EN
    es = m_stall_n; ef = m_flush_n; eb = m_bubble_n;
`else
    es = '0; ef = '0; eb = '0;
`endif
    checks++;
    assert ({perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt} === {es, ef, eb}) else begin
      errors++;
      $error("FAIL %s_cnt: counters %0d/%0d/%0d, expected %0d/%0d/%0d", tag,
             perf_stall_cnt, perf_flush_cnt, perf_bubble_cnt, es, ef, eb);
    end
    if (rst_n) begin
      if (e[8:5] != 4'hf) m_stall_n++;
      if (e[1])           m_flush_n++;
      if (|e[4:2])        m_bubble_n++;
      if (dmem_req && !dmem_ready) m_inflight = m_inflight | (mdu_start & ~mdu_done);
      else                         m_inflight = (e == MDU_K);
    end
    @(negedge clk);
  endtask

  initial begin
    bit op_active;
    int op_left;
    logic [31:0] exp3;
    rst_n = 1'b0;
    drive(0,0,0,0,0,0,5'd0,5'd0,5'd0);
    m_inflight = 0; m_stall_n = 0; m_flush_n = 0; m_bubble_n = 0;
    @(negedge clk);
    cyc("reset_idle", IDLE_K, 1);
    rst_n = 1'b1;
    cyc("run_idle", IDLE_K, 1);

    drive(0,0,0,0,0,1,5'd5,5'd7,5'd5); cyc("load_use", LU_K, 1);
    drive(0,0,0,0,0,0,5'd5,5'd7,5'd5); cyc("load_use_one", IDLE_K, 1);
    drive(0,0,0,0,0,1,5'd0,5'd0,5'd0); cyc("load_use_x0", IDLE_K, 1);

    drive(1,0,0,0,0,0,5'd0,5'd0,5'd0); cyc("mem_w1", MEM_K, 1);
    cyc("mem_w2", MEM_K, 1);
    drive(1,1,0,0,0,0,5'd0,5'd0,5'd0); cyc("mem_rel", IDLE_K, 1);
    cyc("mem_fast", IDLE_K, 1);

    drive(0,0,1,0,0,0,5'd0,5'd0,5'd0); cyc("mm_mdu1", MDU_K, 1);
    cyc("mm_mdu2", MDU_K, 1);
    drive(1,0,1,0,0,0,5'd0,5'd0,5'd0); cyc("mm_mem1", MEM_K, 1);
    cyc("mm_mem2", MEM_K, 1);
    drive(1,1,1,0,0,0,5'd0,5'd0,5'd0); cyc("mm_resume", MDU_K, 1);
    drive(0,0,1,0,0,0,5'd0,5'd0,5'd0); cyc("mm_mdu3", MDU_K, 1);
    cyc("mm_mdu4", MDU_K, 1);
    drive(0,0,1,1,0,0,5'd0,5'd0,5'd0); cyc("mm_done", IDLE_K, 1);

    drive(0,0,0,0,1,1,5'd3,5'd3,5'd1); cyc("br_lu", BR_K, 1);
    drive(1,0,0,0,1,0,5'd0,5'd0,5'd0); cyc("br_memstall", MEM_K, 1);
    drive(1,1,0,0,1,0,5'd0,5'd0,5'd0); cyc("br_release", BR_K, 1);

    drive(0,0,1,0,0,0,5'd0,5'd0,5'd0); cyc("rst_mdu1", MDU_K, 1);
    cyc("rst_mdu2", MDU_K, 1);
    rst_n = 1'b0;
    drive(0,0,0,0,0,0,5'd0,5'd0,5'd0); cyc("rst_mid", IDLE_K, 1);
    rst_n = 1'b1;
    cyc("rst_after", IDLE_K, 1);

    drive(0,0,1,0,0,0,5'd0,5'd0,5'd0);
    for (int i = 0; i < 3; i++) cyc("mdu4_stall", MDU_K, 1);
    drive(0,0,1,1,0,0,5'd0,5'd0,5'd0); cyc("mdu4_done", IDLE_K, 1);
    drive(0,0,0,0,0,0,5'd0,5'd0,5'd0); cyc("mdu4_run", IDLE_K, 1);
`ifdef PERF_COUNTERS_EN
    exp3 = 32'd3;
`else
    exp3 = 32'd0;
`endif
    checks++;
    assert (perf_stall_cnt === exp3 && perf_bubble_cnt === exp3) else begin
      errors++;
      $error("FAIL mdu_counters: stall %0d bubble %0d, expected %0d", perf_stall_cnt,
             perf_bubble_cnt, exp3);
    end

    op_active = 0;
    op_left = 0;
    for (int i = 0; i < 2000; i++) begin
      logic req, rdy, dn;
      req = ($urandom_range(0, 2) == 0);
      rdy = $urandom_range(0, 1) == 1;
      if (!op_active && $urandom_range(0, 5) == 0) begin
        op_active = 1;
        op_left = $urandom_range(1, 4);
      end
      dn = 1'b0;
      if (op_active && !(req && !rdy)) begin
        if (op_left <= 1) dn = 1'b1;
        else op_left--;
      end
      drive(req, rdy, op_active, dn, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      cyc("random", IDLE_K, 0);
      if (dn) op_active = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
